femto_bus_fabric: RTL

Parametrised memory-mapped interconnect between the FemtoRV32 data/instruction port and N peripheral slaves, replacing the fixed 7-way chip-select case and read mux in the femto top level. It decodes a configurable address field against a per-slave tag table, pulses the selected slave's read/write strobe, and holds the response mux on the latched slave. It merges busy signals and aborts hung transactions with a timeout that returns a fixed error word and captures the faulting address.

---
 rtl/femto_bus_pkg.sv | 8 +
 rtl/femto_addr_decode.sv | 17 +
 rtl/femto_bus_fabric.sv | 84 ++++++++
 3 files changed

// File: rtl/femto_bus_pkg.sv
// femto_bus_pkg: shared constants, state encoding and sizing helper for the femto bus fabric
package femto_bus_pkg;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/femto_addr_decode.sv
// femto_addr_decode: priority tag match of an address field, lowest index wins, default on miss
module femto_addr_decode import femto_bus_pkg::*; #(
  parameter int N = 4,
  parameter int FW = 16,
  parameter logic [N*FW-1:0] TAGS = '0,
  parameter int DEFAULT_IDX = 0,
  localparam int IW = clog2_min1(N)
) (
  input  logic [FW-1:0] field,
  output logic [IW-1:0] sel
);
  always_comb begin
    sel = IW'(DEFAULT_IDX);
    for (int i = N - 1; i >= 0; i--)
      if (field == TAGS[i*FW +: FW]) sel = IW'(i);
  end
endmodule

// File: rtl/femto_bus_fabric.sv
// femto_bus_fabric: decoded strobe fan-out, busy merge, timeout abort and error capture for N slaves
module femto_bus_fabric import femto_bus_pkg::*; #(
  parameter int NSLAVES = 4,
  parameter int DATA_W = 32,
  parameter int SEL_HI = 31,
  parameter int SEL_LO = 16,
  parameter logic [NSLAVES*(SEL_HI-SEL_LO+1)-1:0] SLAVE_TAGS = {16'h0001, 16'h0040, 16'h0000, 16'h0000},
  parameter int DEFAULT_SLAVE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [31:0]               mem_addr,
  input  logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W/8-1:0]       mem_wmask,
  input  logic                      mem_rstrb,
  output logic [DATA_W-1:0]         mem_rdata,
  output logic                      mem_rbusy,
  output logic                      mem_wbusy,
  output logic [NSLAVES-1:0]        s_rd,
  output logic [NSLAVES-1:0]        s_wr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [NSLAVES*DATA_W-1:0] s_rdata,
  input  logic [NSLAVES-1:0]        s_rbusy,
  input  logic [NSLAVES-1:0]        s_wbusy,
  output logic                      err_valid,
  output logic [31:0]               err_addr,
  input  logic                      err_clr
);
  localparam int IW = clog2_min1(NSLAVES);
  localparam int CW = clog2_min1(TIMEOUT + 1);
  localparam int FW = SEL_HI - SEL_LO + 1;
  state_t state, state_nx;
  logic [IW-1:0] sel, sel_q;
  logic [31:0] addr_q;
  logic [CW-1:0] cnt, cnt_nx;
  logic abort_q, issue, wr_req, waiting, busy_sel, timeout;
  femto_addr_decode #(
    .N(NSLAVES), .FW(FW), .TAGS(SLAVE_TAGS), .DEFAULT_IDX(DEFAULT_SLAVE)
  ) u_dec (
    .field(mem_addr[SEL_HI:SEL_LO]),
    .sel  (sel)
  );
  assign s_wdata = mem_wdata;
  // resetn gates issue so strobes drop immediately while reset is held
  always_comb begin
    wr_req = |mem_wmask;
    issue = resetn && state == IDLE && (wr_req || mem_rstrb);
    waiting = state != IDLE;
    busy_sel = state == WR_WAIT ? s_wbusy[sel_q] : s_rbusy[sel_q];
    timeout = (TIMEOUT != 0) && waiting && busy_sel && cnt == CW'(TIMEOUT);
    s_wr = issue && wr_req ? NSLAVES'(1) << sel : '0;
    s_rd = issue && !wr_req ? NSLAVES'(1) << sel : '0;
    mem_rbusy = state == RD_WAIT && busy_sel && !timeout;
    mem_wbusy = state == WR_WAIT && busy_sel && !timeout;
    state_nx = issue ? (wr_req ? WR_WAIT : RD_WAIT) : waiting && (!busy_sel || timeout) ? IDLE : state;
    cnt_nx = issue || !waiting || !busy_sel || timeout ? '0 : cnt + 1'b1;
    mem_rdata = abort_q ? DATA_W'(ERR_DATA) : s_rdata[sel_q*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      sel_q <= IW'(DEFAULT_SLAVE);
      addr_q <= '0;
      cnt <= '0;
      abort_q <= 1'b0;
      err_valid <= 1'b0;
      err_addr <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (issue) begin
        sel_q <= sel;
        addr_q <= mem_addr;
        abort_q <= 1'b0;
      end else if (timeout) abort_q <= 1'b1;
      // a fresh timeout overrides a same-cycle clear and re-captures the address
      if (timeout && (!err_valid || err_clr)) begin
        err_valid <= 1'b1;
        err_addr <= addr_q;
      end else if (err_clr) err_valid <= 1'b0;
    end
  end
endmodule
